// File: rtl/lift_scheduler.sv
// SCAN-ordered scheduler and motion sequencer for a single lift car.
// Collects floor calls, picks direction, times travel/door hold and drives up/down/open.
module lift_scheduler #(
    parameter int NUM_FLOORS    = 5,
    parameter int LVL_W         = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_valid,
    input  logic [LVL_W-1:0]      call_lvl,
    output logic                  up,
    output logic                  down,
    output logic                  open,
    output logic [LVL_W-1:0]      cur_lvl,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  arrive,
    output logic                  call_err
);

    localparam int TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] TRAVEL_LAST = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0] DOOR_LAST   = TMR_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        OPEN      = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [LVL_W-1:0]        cur_lvl_q, cur_lvl_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic                    dir_q, dir_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic                    arrive_q, arrive_d;
    logic                    call_err_q, call_err_d;

    logic                    call_in_range;
    logic                    call_absorb;
    logic                    step;
    logic [LVL_W-1:0]        next_lvl;
    logic [NUM_FLOORS-1:0]   set_mask;
    logic [NUM_FLOORS-1:0]   clear_mask;
    logic [NUM_FLOORS-1:0]   seen_mask;

    function automatic logic [NUM_FLOORS-1:0] onehot_mask(input logic [LVL_W-1:0] lvl);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (i == 32'(lvl));
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [LVL_W-1:0] lvl);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (i > 32'(lvl));
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [LVL_W-1:0] lvl);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (i < 32'(lvl));
        return m;
    endfunction

    always_comb begin
        call_in_range = call_valid && (32'(call_lvl) < NUM_FLOORS);
        call_absorb   = call_in_range && (state_q == OPEN) && (call_lvl == cur_lvl_q);
        set_mask      = (call_in_range && !call_absorb) ? onehot_mask(call_lvl) : '0;
        // A call landing on the arrival edge counts as a request for that floor.
        seen_mask     = pending_q | set_mask;
        next_lvl      = (state_q == MOVE_DOWN) ? cur_lvl_q - LVL_W'(1) : cur_lvl_q + LVL_W'(1);
        step          = ((state_q == MOVE_UP) || (state_q == MOVE_DOWN)) && (tmr_q == TRAVEL_LAST);

        state_d    = state_q;
        cur_lvl_d  = cur_lvl_q;
        dir_d      = dir_q;
        tmr_d      = tmr_q;
        clear_mask = '0;
        arrive_d   = step;
        call_err_d = call_valid && !call_in_range;

        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (|(pending_q & onehot_mask(cur_lvl_q))) begin
                    state_d    = OPEN;
                    clear_mask = onehot_mask(cur_lvl_q);
                end else if (|(pending_q & above_mask(cur_lvl_q)) &&
                             (dir_q || !(|(pending_q & below_mask(cur_lvl_q))))) begin
                    state_d = MOVE_UP;
                    dir_d   = 1'b1;
                end else if (|(pending_q & below_mask(cur_lvl_q))) begin
                    state_d = MOVE_DOWN;
                    dir_d   = 1'b0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (step) begin
                    cur_lvl_d = next_lvl;
                    tmr_d     = '0;
                    if (|(seen_mask & onehot_mask(next_lvl))) begin
                        state_d    = OPEN;
                        clear_mask = onehot_mask(next_lvl);
                    end else if ((state_q == MOVE_UP)   && |(seen_mask & above_mask(next_lvl))) begin
                        state_d = MOVE_UP;
                    end else if ((state_q == MOVE_DOWN) && |(seen_mask & below_mask(next_lvl))) begin
                        state_d = MOVE_DOWN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            OPEN: begin
                if (call_absorb) begin
                    tmr_d = '0;
                end else if (tmr_q == DOOR_LAST) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase

        pending_d = (pending_q | set_mask) & ~clear_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_lvl_q  <= '0;
            pending_q  <= '0;
            dir_q      <= 1'b1;
            tmr_q      <= '0;
            arrive_q   <= 1'b0;
            call_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_lvl_q  <= cur_lvl_d;
            pending_q  <= pending_d;
            dir_q      <= dir_d;
            tmr_q      <= tmr_d;
            arrive_q   <= arrive_d;
            call_err_q <= call_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(step && (state_q == MOVE_UP) && (32'(cur_lvl_q) >= NUM_FLOORS - 1)));
            assert (!(step && (state_q == MOVE_DOWN) && (cur_lvl_q == '0)));
        end
    end

    assign up       = (state_q == MOVE_UP);
    assign down     = (state_q == MOVE_DOWN);
    assign open     = (state_q == OPEN);
    assign cur_lvl  = cur_lvl_q;
    assign pending  = pending_q;
    assign arrive   = arrive_q;
    assign call_err = call_err_q;

endmodule

// File: tb/tb_lift_scheduler.sv
// Directed bench for lift_scheduler: hand-computed expectations for reset, door, travel,
// SCAN ordering, out-of-range calls and door-hold extension.
module tb_lift_scheduler;

    logic       clk;
    logic       reset;
    logic       call_valid;
    logic [2:0] call_lvl;
    logic       up, down, open;
    logic [2:0] cur_lvl;
    logic [4:0] pending;
    logic       arrive, call_err;

    int unsigned passes = 0;
    int unsigned total  = 0;

    lift_scheduler #(
        .NUM_FLOORS   (5),
        .LVL_W        (3),
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .call_valid(call_valid),
        .call_lvl  (call_lvl),
        .up        (up),
        .down      (down),
        .open      (open),
        .cur_lvl   (cur_lvl),
        .pending   (pending),
        .arrive    (arrive),
        .call_err  (call_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic call(input logic [2:0] lvl);
        call_valid = 1'b1;
        call_lvl   = lvl;
        tick();
        call_valid = 1'b0;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // udo = {up, down, open}
    task automatic chk(input string tag, input logic [2:0] e_udo, input logic [2:0] e_lvl,
                       input logic [4:0] e_pend, input logic e_arr, input logic e_err);
        cmp({tag, ".udo"},      32'({up, down, open}), 32'(e_udo));
        cmp({tag, ".cur_lvl"},  32'(cur_lvl),          32'(e_lvl));
        cmp({tag, ".pending"},  32'(pending),          32'(e_pend));
        cmp({tag, ".arrive"},   32'(arrive),           32'(e_arr));
        cmp({tag, ".call_err"}, 32'(call_err),         32'(e_err));
    endtask

    initial begin
        reset      = 1'b1;
        call_valid = 1'b0;
        call_lvl   = '0;
        tick_n(2);
        reset = 1'b0;
        chk("reset", 3'b000, 3'd0, 5'b00000, 1'b0, 1'b0);

        // Call at current floor: door opens for two cycles, then idle.
        call(3'd0);
        chk("t1.k",   3'b000, 3'd0, 5'b00001, 1'b0, 1'b0);
        tick();
        chk("t1.k1",  3'b001, 3'd0, 5'b00000, 1'b0, 1'b0);
        tick();
        chk("t1.k2",  3'b001, 3'd0, 5'b00000, 1'b0, 1'b0);
        tick();
        chk("t1.k3",  3'b000, 3'd0, 5'b00000, 1'b0, 1'b0);
        tick();
        chk("t1.k4",  3'b000, 3'd0, 5'b00000, 1'b0, 1'b0);

        // Travel 0 -> 2, then extend the door hold with a call for floor 2.
        call(3'd2);
        chk("t2.k",   3'b000, 3'd0, 5'b00100, 1'b0, 1'b0);
        tick();
        chk("t2.k1",  3'b100, 3'd0, 5'b00100, 1'b0, 1'b0);
        tick_n(3);
        chk("t2.k4",  3'b100, 3'd0, 5'b00100, 1'b0, 1'b0);
        tick();
        chk("t2.k5",  3'b100, 3'd1, 5'b00100, 1'b1, 1'b0);
        tick();
        chk("t2.k6",  3'b100, 3'd1, 5'b00100, 1'b0, 1'b0);
        tick_n(3);
        chk("t2.k9",  3'b001, 3'd2, 5'b00000, 1'b1, 1'b0);
        tick();
        chk("t2.k10", 3'b001, 3'd2, 5'b00000, 1'b0, 1'b0);
        call(3'd2);
        chk("t2.k11", 3'b001, 3'd2, 5'b00000, 1'b0, 1'b0);
        tick();
        chk("t2.k12", 3'b001, 3'd2, 5'b00000, 1'b0, 1'b0);
        tick();
        chk("t2.k13", 3'b000, 3'd2, 5'b00000, 1'b0, 1'b0);

        // Out-of-range calls.
        call(3'd5);
        chk("t3.err5",  3'b000, 3'd2, 5'b00000, 1'b0, 1'b1);
        tick();
        chk("t3.clear", 3'b000, 3'd2, 5'b00000, 1'b0, 1'b0);
        call(3'd7);
        chk("t3.err7",  3'b000, 3'd2, 5'b00000, 1'b0, 1'b1);
        tick();
        chk("t3.idle",  3'b000, 3'd2, 5'b00000, 1'b0, 1'b0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset2", 3'b000, 3'd0, 5'b00000, 1'b0, 1'b0);

        // SCAN sweep: 0 -> 3 -> 4 -> 0.
        call(3'd4);
        chk("t4.k",   3'b000, 3'd0, 5'b10000, 1'b0, 1'b0);
        tick();
        chk("t4.k1",  3'b100, 3'd0, 5'b10000, 1'b0, 1'b0);
        tick_n(4);
        chk("t4.k5",  3'b100, 3'd1, 5'b10000, 1'b1, 1'b0);
        call(3'd0);
        chk("t4.k6",  3'b100, 3'd1, 5'b10001, 1'b0, 1'b0);
        call(3'd3);
        chk("t4.k7",  3'b100, 3'd1, 5'b11001, 1'b0, 1'b0);
        tick_n(2);
        chk("t4.k9",  3'b100, 3'd2, 5'b11001, 1'b1, 1'b0);
        tick_n(4);
        chk("t4.k13", 3'b001, 3'd3, 5'b10001, 1'b1, 1'b0);
        tick_n(2);
        chk("t4.k15", 3'b000, 3'd3, 5'b10001, 1'b0, 1'b0);
        tick();
        chk("t4.k16", 3'b100, 3'd3, 5'b10001, 1'b0, 1'b0);
        tick_n(4);
        chk("t4.k20", 3'b001, 3'd4, 5'b00001, 1'b1, 1'b0);
        tick_n(2);
        chk("t4.k22", 3'b000, 3'd4, 5'b00001, 1'b0, 1'b0);
        tick();
        chk("t4.k23", 3'b010, 3'd4, 5'b00001, 1'b0, 1'b0);
        tick_n(4);
        chk("t4.k27", 3'b010, 3'd3, 5'b00001, 1'b1, 1'b0);
        tick_n(12);
        chk("t4.k39", 3'b001, 3'd0, 5'b00000, 1'b1, 1'b0);
        tick_n(2);
        chk("t4.k41", 3'b000, 3'd0, 5'b00000, 1'b0, 1'b0);

        // Reset mid-move, with a call presented during reset.
        call(3'd2);
        chk("t5.k",   3'b000, 3'd0, 5'b00100, 1'b0, 1'b0);
        tick();
        chk("t5.k1",  3'b100, 3'd0, 5'b00100, 1'b0, 1'b0);
        tick_n(5);
        chk("t5.k6",  3'b100, 3'd1, 5'b00100, 1'b0, 1'b0);
        reset      = 1'b1;
        call_valid = 1'b1;
        call_lvl   = 3'd3;
        tick();
        reset      = 1'b0;
        call_valid = 1'b0;
        chk("t5.rst",  3'b000, 3'd0, 5'b00000, 1'b0, 1'b0);
        tick();
        chk("t5.post", 3'b000, 3'd0, 5'b00000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/lift_scheduler.md
# lift_scheduler

SCAN-ordered scheduler and motion sequencer for a single lift car. Collects floor calls from any source into a pending-request mask, chooses travel direction with an elevator (SCAN) policy, times per-floor travel and door hold, and drives the car's `up`/`down`/`open` controls. It sits between the call-button front end and the car drive, and provides position and status to the rest of the design.

## Interface

Parameters:
- `NUM_FLOORS`, default 5: number of floors, numbered 0..NUM_FLOORS-1.
- `LVL_W`, default 3: width of floor numbers; 2^LVL_W >= NUM_FLOORS.
- `TRAVEL_CYCLES`, default 4: cycles to move one floor; must be >= 1.
- `DOOR_CYCLES`, default 2: cycles the door stays open; must be >= 1.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `call_valid` in 1: floor call present this cycle.
- `call_lvl` in LVL_W: requested floor, qualified by `call_valid`.
- `up` out 1: car moving up.
- `down` out 1: car moving down.
- `open` out 1: door open.
- `cur_lvl` out LVL_W: current floor.
- `pending` out NUM_FLOORS: registered request mask; bit i set means floor i is awaiting service.
- `arrive` out 1: one-cycle pulse in the cycle after `cur_lvl` changes.
- `call_err` out 1: one-cycle pulse for an out-of-range call.

## Operation

- Registers: `state`, `cur_lvl`, `pending`, `dir` (1 = up, 0 = down), `tmr` (wide enough for max(TRAVEL_CYCLES, DOOR_CYCLES)).
- States:
  - IDLE: `up`, `down` and `open` all 0.
  - MOVE_UP: `up` = 1 only.
  - MOVE_DOWN: `down` = 1 only.
  - OPEN: `open` = 1 only.
- All outputs decode from registers. `up`, `down` and `open` are mutually exclusive (one-hot or zero).
- Call capture, applied at the edge where `call_valid` is sampled:
  - If `call_lvl >= NUM_FLOORS`: `call_err` pulses next cycle and `pending` is unchanged.
  - If state is OPEN and `call_lvl == cur_lvl`: the call is absorbed, no bit is set, and `tmr` restarts at 0, so the hold is extended.
  - Otherwise: `pending[call_lvl]` is set. Calls for an already-pending floor have no effect.
- IDLE decisions, evaluated on the registered `pending`, in priority order:
  1. `pending[cur_lvl]` set: go to OPEN.
  2. Any bit above `cur_lvl` and (`dir` = 1 or no bit below): go to MOVE_UP, set `dir` = 1.
  3. Any bit below: go to MOVE_DOWN, set `dir` = 0.
  4. Otherwise stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - `tmr` counts 0..TRAVEL_CYCLES-1.
  - At `tmr == TRAVEL_CYCLES-1`: `cur_lvl` steps by ±1 and `tmr` returns to 0.
  - Then, if the new floor's bit is set, go to OPEN. Else, if bits remain in the current direction, stay in the move state. Else go to IDLE.
  - `cur_lvl` never leaves 0..NUM_FLOORS-1; a step past the boundary is impossible by construction and must be asserted against in simulation.
- OPEN:
  - On entry, `tmr` = 0 and `pending[cur_lvl]` is cleared. Clearing takes priority over a same-edge set for that floor.
  - The door holds DOOR_CYCLES cycles, then goes to IDLE.
  - `dir` is kept, so the next IDLE decision continues the sweep.
- Reset: `state` = IDLE, `cur_lvl` = 0, `pending` = 0, `dir` = 1, `tmr` = 0, `arrive` = 0, `call_err` = 0. Calls sampled during reset are dropped. Reset mid-move or mid-open aborts immediately, with no partial floor step.

## Timing

- A call sampled at edge k makes `pending` visible after edge k.
- An IDLE decision takes effect at edge k+1. From IDLE, the move or open output asserts after edge k+1.
- Travel: the floor step occurs TRAVEL_CYCLES edges after entering the move state. `arrive` is high for the following cycle.
- Arrival at a requested floor: `up`/`down` fall and `open` rises at the same edge as the `cur_lvl` update.
- OPEN lasts exactly DOOR_CYCLES cycles unless extended. This is followed by at least one IDLE cycle before any movement.
- Simultaneous arrival and call for the arrival floor: the call is absorbed, and `pending` for that floor reads 0 after the edge.

## Test plan

- Assert `reset` during a move → after next edge: `up`=`down`=`open`=0, `cur_lvl`=0, `pending`=0, `arrive`=`call_err`=0.
- At floor 0 in IDLE, call 0 sampled at edge k → `pending`=00001 after k; `open`=1 after k+1 for 2 cycles; IDLE after k+3 with `pending`=0.
- From floor 0, call 2 at edge k → `up`=1 after k+1; `cur_lvl`=1 after k+5 (`arrive` pulse, `up` stays 1); `cur_lvl`=2 with `open`=1, `up`=0 after k+9.
- Call 4 from floor 0; while at `cur_lvl`=1 moving up, call 0 and call 3 → stops at 3, then 4, then reverses and serves 0; `pending` reaches 0 after the last OPEN.
- Call `call_lvl`=5 → `call_err`=1 for one cycle, `pending` unchanged, no motion.
- While OPEN at floor 2 in the second open cycle, call 2 → `open` held 2 more cycles, `pending[2]` stays 0.
